// File: rtl/calc_operand_entry.sv
// rtl/calc_operand_entry.sv - operand/operation entry sequencer and registered ALU for the calculator
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   SW           slide switches (already synchronous to clk)
//   enter_pulse  one-cycle advance pulse
//   back_pulse   one-cycle step-back pulse
//   OP1, OP2     operand registers
//   result       registered ALU result
//   state        entry state: 0 WAIT_OP1, 1 WAIT_OP2, 2 WAIT_OP, 3 SHOW
//   op_code      latched operation (00 ADD, 01 SUB, 10 AND, 11 OR)
//   result_valid high while in SHOW
//   flags        {N, Z, C, V}, registered together with result

module calc_operand_entry #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] SW,
  input  logic         enter_pulse,
  input  logic         back_pulse,
  output logic [N-1:0] OP1,
  output logic [N-1:0] OP2,
  output logic [N-1:0] result,
  output logic [1:0]   state,
  output logic [1:0]   op_code,
  output logic         result_valid,
  output logic [3:0]   flags
);

  typedef enum logic [1:0] {
    WAIT_OP1 = 2'd0,
    WAIT_OP2 = 2'd1,
    WAIT_OP  = 2'd2,
    SHOW     = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [N-1:0] r_op1;
  logic [N-1:0] r_op2;
  logic [N-1:0] r_result;
  logic [1:0]   r_op_code;
  logic [3:0]   r_flags;

  // ALU is evaluated combinationally on the live SW op bits so that the
  // WAIT_OP -> SHOW edge registers the result of the operation being latched.
  logic [N:0]   w_sum;
  logic [N-1:0] w_diff;
  logic [N-1:0] w_alu_res;
  logic         w_alu_c;
  logic         w_alu_v;
  logic [3:0]   w_alu_flags;

  assign w_sum  = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_diff = r_op1 - r_op2;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (SW[1:0])
      2'b00: begin
        w_alu_res = w_sum[N-1:0];
        w_alu_c   = w_sum[N];
        w_alu_v   = (r_op1[N-1] == r_op2[N-1]) && (w_sum[N-1] != r_op1[N-1]);
      end
      2'b01: begin
        w_alu_res = w_diff;
        w_alu_c   = (r_op1 < r_op2);
        w_alu_v   = (r_op1[N-1] != r_op2[N-1]) && (w_diff[N-1] != r_op1[N-1]);
      end
      2'b10: w_alu_res = r_op1 & r_op2;
      default: w_alu_res = r_op1 | r_op2;
    endcase
    w_alu_flags = {w_alu_res[N-1], (w_alu_res == '0), w_alu_c, w_alu_v};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_OP1;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; enter has priority over back
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_OP1: if (enter_pulse) w_next_state = WAIT_OP2;
      WAIT_OP2: begin
        if (enter_pulse)     w_next_state = WAIT_OP;
        else if (back_pulse) w_next_state = WAIT_OP1;
      end
      WAIT_OP: begin
        if (enter_pulse)     w_next_state = SHOW;
        else if (back_pulse) w_next_state = WAIT_OP2;
      end
      default: begin
        if (enter_pulse)     w_next_state = WAIT_OP1;
        else if (back_pulse) w_next_state = WAIT_OP;
      end
    endcase
  end

  // Datapath registers. The tracked register keeps loading SW on the
  // advancing edge too, which is what freezes the value seen at enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_result  <= '0;
      r_op_code <= '0;
      r_flags   <= '0;
    end else begin
      case (r_state)
        WAIT_OP1: r_op1 <= SW;
        WAIT_OP2: begin
          if (!enter_pulse && back_pulse) r_op2 <= '0;
          else                            r_op2 <= SW;
        end
        WAIT_OP: begin
          if (enter_pulse) begin
            r_op_code <= SW[1:0];
            r_result  <= w_alu_res;
            r_flags   <= w_alu_flags;
          end else if (back_pulse) begin
            r_op_code <= '0;
          end else begin
            r_op_code <= SW[1:0];
          end
        end
        default: begin
          if (enter_pulse) begin
            r_op2     <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_op_code <= '0;
          end else if (back_pulse) begin
            r_result  <= '0;
            r_flags   <= '0;
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    state        = r_state;
    result_valid = (r_state == SHOW);
    OP1          = r_op1;
    OP2          = r_op2;
    result       = r_result;
    op_code      = r_op_code;
    flags        = r_flags;
  end

endmodule

// File: tb/tb_calc_operand_entry.sv
// tb/tb_calc_operand_entry.sv - self-checking bench for calc_operand_entry

module tb_calc_operand_entry;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] SW = '0;
  logic         enter_pulse = 1'b0;
  logic         back_pulse = 1'b0;
  logic [N-1:0] OP1, OP2, result;
  logic [1:0]   state, op_code;
  logic         result_valid;
  logic [3:0]   flags;

  int n_tests = 0;
  int n_fail  = 0;

  calc_operand_entry #(.N(N)) dut (
    .clk(clk), .rst(rst), .SW(SW), .enter_pulse(enter_pulse), .back_pulse(back_pulse),
    .OP1(OP1), .OP2(OP2), .result(result), .state(state), .op_code(op_code),
    .result_valid(result_valid), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference model: entry phase as an integer, arithmetic on plain ints
  int         m_st;
  logic [15:0] m_op1, m_op2, m_res;
  logic [1:0]  m_opc;
  logic [3:0]  m_flags;

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic model_alu(input int a, input int b, input int op);
    int r, c, v, s;
    c = 0; v = 0;
    case (op)
      0: begin
        r = a + b; c = (r >= 65536); r = r % 65536;
        s = sx(a) + sx(b); v = (s > 32767 || s < -32768);
      end
      1: begin
        r = (a - b + 65536) % 65536; c = (a < b);
        s = sx(a) - sx(b); v = (s > 32767 || s < -32768);
      end
      2: r = a & b;
      default: r = a | b;
    endcase
    m_res   = 16'(r);
    m_flags = {r >= 32768, r == 0, c != 0, v != 0};
  endtask

  task automatic model_reset();
    m_st = 0; m_op1 = '0; m_op2 = '0; m_res = '0; m_opc = '0; m_flags = '0;
  endtask

  task automatic model_step(input logic [15:0] sw, input logic en, input logic bk);
    case (m_st)
      0: begin m_op1 = sw; if (en) m_st = 1; end
      1: begin
        if (en) begin m_op2 = sw; m_st = 2; end
        else if (bk) begin m_op2 = '0; m_st = 0; end
        else m_op2 = sw;
      end
      2: begin
        if (en) begin m_opc = sw[1:0]; model_alu(int'(m_op1), int'(m_op2), int'(sw[1:0])); m_st = 3; end
        else if (bk) begin m_opc = '0; m_st = 1; end
        else m_opc = sw[1:0];
      end
      default: begin
        if (en) begin m_op2 = '0; m_res = '0; m_flags = '0; m_opc = '0; m_st = 0; end
        else if (bk) begin m_res = '0; m_flags = '0; m_st = 2; end
      end
    endcase
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge
  task automatic cycle(input logic [15:0] sw, input logic en, input logic bk);
    SW = sw; enter_pulse = en; back_pulse = bk;
    @(posedge clk);
    #1;
    enter_pulse = 1'b0; back_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({state, OP1, OP2, result, op_code, result_valid, flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d OP1=%h OP2=%h result=%h op=%0d rv=%b flags=%b, required all 0",
               state, OP1, OP2, result, op_code, result_valid, flags);
    end
    cycle(16'h1234, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0);
    n_tests++;
    if (result !== 16'h1234 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_setup: result=%h state=%0d, required 1234 and 3", result, state);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({state, OP1, OP2, result, op_code, result_valid, flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: state=%0d OP1=%h result=%h rv=%b, required all 0 before edge",
               state, OP1, result, result_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    cycle(16'hFFFF, 1'b1, 1'b0);
    cycle(16'h0001, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0);
    n_tests++;
    if (state !== 2'd3 || result !== 16'h0000 || flags !== 4'b0110 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL add_carry: state=%0d result=%h flags=%b rv=%b, required 3 0000 0110 1",
               state, result, flags, result_valid);
    end
    cycle(16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    cycle(16'h0003, 1'b1, 1'b0);
    cycle(16'h0005, 1'b1, 1'b0);
    cycle(16'h0001, 1'b1, 1'b0);
    n_tests++;
    if (result !== 16'hFFFE || flags !== 4'b1010 || op_code !== 2'd1) begin
      n_fail++;
      $display("FAIL sub_borrow: result=%h flags=%b op=%0d, required fffe 1010 1", result, flags, op_code);
    end
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h8000, 1'b1, 1'b0);
    cycle(16'h0001, 1'b1, 1'b0);
    cycle(16'h0001, 1'b1, 1'b0);
    n_tests++;
    if (result !== 16'h7FFF || flags !== 4'b0001) begin
      n_fail++;
      $display("FAIL sub_overflow: result=%h flags=%b, required 7fff 0001", result, flags);
    end
    cycle(16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_nav();
    cycle(16'h00AA, 1'b1, 1'b0);
    cycle(16'h0055, 1'b1, 1'b0);
    cycle(16'h0002, 1'b0, 1'b0);
    n_tests++;
    if (state !== 2'd2 || op_code !== 2'd2) begin
      n_fail++;
      $display("FAIL back_wait_op: state=%0d op=%0d, required 2 2", state, op_code);
    end
    cycle(16'h0002, 1'b0, 1'b1);
    n_tests++;
    if (state !== 2'd1 || op_code !== 2'd0 || OP2 !== 16'h0055) begin
      n_fail++;
      $display("FAIL back_to_op2: state=%0d op=%0d OP2=%h, required 1 0 0055", state, op_code, OP2);
    end
    cycle(16'h1234, 1'b0, 1'b0);
    n_tests++;
    if (OP2 !== 16'h1234) begin
      n_fail++;
      $display("FAIL back_op2_track: OP2=%h, required 1234", OP2);
    end
    cycle(16'h0F0F, 1'b1, 1'b0);
    cycle(16'h0003, 1'b1, 1'b0);
    n_tests++;
    if (result !== 16'h0FAF || flags !== 4'b0000 || OP1 !== 16'h00AA) begin
      n_fail++;
      $display("FAIL back_or: result=%h flags=%b OP1=%h, required 0faf 0000 00aa", result, flags, OP1);
    end
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h0000, 1'b0, 1'b1);
    n_tests++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL back_in_op1: state=%0d, required 0", state);
    end
  endtask

  task automatic test_simultaneous();
    cycle(16'h0001, 1'b1, 1'b0);
    cycle(16'hBEEF, 1'b1, 1'b1);
    n_tests++;
    if (state !== 2'd2 || OP2 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL simultaneous: state=%0d OP2=%h, required 2 beef", state, OP2);
    end
    cycle(16'h1234, 1'b0, 1'b0);
    n_tests++;
    if (OP2 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL op2_frozen: OP2=%h, required beef", OP2);
    end
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_tracking_show();
    cycle(16'h1111, 1'b0, 1'b0);
    SW = 16'h2222;
    #2;
    n_tests++;
    if (OP1 !== 16'h1111) begin
      n_fail++;
      $display("FAIL track_lag: OP1=%h, required 1111 before edge", OP1);
    end
    cycle(16'h2222, 1'b0, 1'b0);
    n_tests++;
    if (OP1 !== 16'h2222) begin
      n_fail++;
      $display("FAIL track_follow: OP1=%h, required 2222", OP1);
    end
    cycle(16'h2222, 1'b1, 1'b0);
    cycle(16'h0003, 1'b1, 1'b0);
    cycle(16'h0001, 1'b1, 1'b0);
    cycle(16'hFFFF, 1'b0, 1'b0);
    cycle(16'hA5A5, 1'b0, 1'b0);
    n_tests++;
    if (OP1 !== 16'h2222 || OP2 !== 16'h0003 || result !== 16'h221F || flags !== 4'b0000 ||
        op_code !== 2'd1 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL show_stable: OP1=%h OP2=%h result=%h flags=%b op=%0d state=%0d, required 2222 0003 221f 0000 1 3",
               OP1, OP2, result, flags, op_code, state);
    end
    cycle(16'hA5A5, 1'b1, 1'b0);
    n_tests++;
    if (state !== 2'd0 || OP2 !== '0 || result !== '0 || flags !== '0 || op_code !== '0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL show_exit: state=%0d OP2=%h result=%h flags=%b op=%0d rv=%b, required all 0",
               state, OP2, result, flags, op_code, result_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] sw;
    logic        en, bk;
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      sw = 16'($urandom);
      if ($urandom_range(0, 3) == 0) sw = {$urandom_range(0, 1) == 0 ? 1'b1 : 1'b0, 15'($urandom_range(0, 3))};
      en = ($urandom_range(0, 3) == 0);
      bk = ($urandom_range(0, 4) == 0);
      cycle(sw, en, bk);
      model_step(sw, en, bk);
      n_tests++;
      if (state !== 2'(m_st) || OP1 !== m_op1 || OP2 !== m_op2 || op_code !== m_opc ||
          result !== m_res || flags !== m_flags || result_valid !== (m_st == 3)) begin
        n_fail++;
        $display("FAIL random[%0d]: got st=%0d OP1=%h OP2=%h op=%0d res=%h fl=%b rv=%b, required st=%0d OP1=%h OP2=%h op=%0d res=%h fl=%b rv=%b",
                 i, state, OP1, OP2, op_code, result, flags, result_valid,
                 m_st, m_op1, m_op2, m_opc, m_res, m_flags, (m_st == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_back_nav();
    test_simultaneous();
    test_tracking_show();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_operand_entry.md
Name: calc_operand_entry

Overview:
- Input-side producer for the calculator datapath; generates the OP1, OP2, result and state values that the 7-segment display subsystem consumes.
- Sequences operand and operation entry from switches, driven by debounced one-cycle button pulses.
- Computes and registers the ALU result and status flags.
- Sits between the PB debouncers / slide switches and the display controller.

Parameters:
- N, 16, operand and result width in bits (N >= 4).

Ports:
- clk  in  1  system clock (CLK100MHZ domain)
- rst  in  1  asynchronous, active-high reset
- SW  in  N  slide switches, already synchronous to clk
- enter_pulse  in  1  one-cycle pulse from debouncer (advance)
- back_pulse  in  1  one-cycle pulse from debouncer (step back)
- OP1  out  N  first operand register
- OP2  out  N  second operand register
- result  out  N  registered ALU result
- state  out  2  entry state, encoding below
- op_code  out  2  latched operation
- result_valid  out  1  high while state==SHOW
- flags  out  4  {N neg, Z zero, C carry/borrow, V signed overflow}, registered with result

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - all outputs 0
  - state = WAIT_OP1 (2'd0)
- Reset asserted mid-operation clears all registers immediately, independent of clk.
- State encoding: WAIT_OP1 = 0, WAIT_OP2 = 1, WAIT_OP = 2, SHOW = 3.
- Live tracking (registered, 1-cycle latency from SW to output):
  - WAIT_OP1: OP1 <= SW every cycle.
  - WAIT_OP2: OP2 <= SW every cycle.
  - WAIT_OP: op_code <= SW[1:0] every cycle.
- Freezing: the edge at which enter_pulse advances the state also captures the current SW into the register being tracked. That value then holds until the next tracking state.
- Transitions on enter_pulse:
  - WAIT_OP1 -> WAIT_OP2
  - WAIT_OP2 -> WAIT_OP
  - WAIT_OP -> SHOW
  - SHOW -> WAIT_OP1, clearing OP2, result, flags and op_code to 0
- Transitions on back_pulse:
  - WAIT_OP2 -> WAIT_OP1: OP2 cleared; OP1 resumes tracking.
  - WAIT_OP -> WAIT_OP2: op_code cleared.
  - SHOW -> WAIT_OP: result, flags and result_valid cleared.
  - In WAIT_OP1: no effect.
- enter_pulse and back_pulse in the same cycle: enter wins, back is ignored.
- Pulses wider than one cycle are not protected against; each high cycle counts as one event.
- ALU evaluation happens on the WAIT_OP -> SHOW edge.
  - Operands: OP1, OP2 and op = SW[1:0] (the same value latched into op_code).
  - result and flags are registered on that same edge, so result_valid and result become visible together one cycle after the enter pulse.
- Operations:
  - 00 ADD: N+1-bit sum; result = low N bits; C = bit N.
  - 01 SUB: result = OP1-OP2 mod 2^N; C = borrow (OP1 < OP2 unsigned).
  - 10 AND: C = 0, V = 0.
  - 11 OR: C = 0, V = 0.
- V (signed overflow):
  - ADD: operands same sign, result sign differs.
  - SUB: operands differ in sign, result sign differs from OP1.
- Z = (result == 0). N = result[N-1].
- Outputs stay stable in SHOW regardless of SW changes.

Test Plan:
- Reset behaviour: assert rst mid-SHOW with result=0x1234 -> all outputs 0 and state=0 asynchronously, before the next clk edge.
- ADD with carry: SW=0xFFFF, enter; SW=0x0001, enter; SW=0b00, enter -> state=3, result=0x0000, flags={0,1,1,0}, result_valid=1 one cycle after the third pulse.
- SUB borrow and signed overflow:
  - OP1=0x0003, OP2=0x0005, SUB -> result=0xFFFE, flags={1,0,1,0}.
  - Repeat with OP1=0x8000, OP2=0x0001 -> result=0x7FFF, flags={0,0,0,1}.
- Back navigation: in WAIT_OP with OP1=0x00AA, OP2=0x0055, back_pulse -> state=1, op_code=0, OP2 follows SW; change SW to 0x0F0F, enter, SW=0b11, enter -> result=0x0FAF.
- Simultaneous pulses: in WAIT_OP2, enter_pulse and back_pulse high in the same cycle -> state=2, OP2 frozen at the SW value of that cycle.
- Live tracking and SHOW exit: in WAIT_OP1, toggle SW 0x1111 -> 0x2222 -> OP1 follows with 1-cycle lag. In SHOW, change SW -> outputs unchanged. enter_pulse -> state=0, OP2=0, result=0, flags=0.
